// File: rtl/sha_host_bridge_if.sv
// Signal bundle between the byte-serial host bus, the hash core and the bridge.
// The bridge uses the slave view; whoever drives the host and core side uses master.
`timescale 1ns/1ps

interface sha_host_bridge_if #(
    parameter int WORD_BYTES = 4,
    parameter int HASH_BYTES = 32,
    parameter int ADDR_W     = 5
);
    logic                    start;
    logic                    abort;
    logic [7:0]              host_data;
    logic                    host_rdy;
    logic                    host_rq;
    logic [7:0]              host_out;
    logic                    host_done;
    logic                    busy;
    logic                    err;
    logic                    core_start;
    logic                    core_rdy;
    logic [WORD_BYTES*8-1:0] core_data;
    logic                    core_rq;
    logic [ADDR_W-1:0]       core_addr;
    logic [HASH_BYTES*8-1:0] core_hash;
    logic                    core_done;

    modport slave (
        input  start, abort, host_data, host_rdy, core_rq, core_addr, core_hash, core_done,
        output host_rq, host_out, host_done, busy, err, core_start, core_rdy, core_data
    );

    modport master (
        output start, abort, host_data, host_rdy, core_rq, core_addr, core_hash, core_done,
        input  host_rq, host_out, host_done, busy, err, core_start, core_rdy, core_data
    );
endinterface

// File: rtl/sha_host_bridge.sv
// Byte-serial bridge: packs host bytes into words requested by a hash core,
// then streams the finished digest back to the host one byte per handshake.
`timescale 1ns/1ps

module sha_host_bridge #(
    parameter int WORD_BYTES     = 4,
    parameter int HASH_BYTES     = 32,
    parameter int OUT_BYTES      = 32,
    parameter int ADDR_W         = 5,
    parameter bit WORD_LSB_FIRST = 1'b0,
    parameter bit HASH_LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    sha_host_bridge_if.slave  bus
);

    localparam int MAX_BYTES = (WORD_BYTES > OUT_BYTES) ? WORD_BYTES : OUT_BYTES;
    localparam int IDX_W     = $clog2(MAX_BYTES + 1);
    localparam int LANE_W    = IDX_W + 3;
    localparam int HASH_W    = HASH_BYTES * 8;
    localparam int HSEL_W    = $clog2(HASH_W) + 1;

    if (WORD_BYTES < 1 || WORD_BYTES > 8) begin : g_bad_word_bytes
        $error("sha_host_bridge: WORD_BYTES must be in 1..8");
    end
    if (OUT_BYTES < 1 || OUT_BYTES > HASH_BYTES) begin : g_bad_out_bytes
        $error("sha_host_bridge: OUT_BYTES must be in 1..HASH_BYTES");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FETCH, S_OUT} state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    hostRq_q;
    logic                    hostDone_q;
    logic                    busy_q;
    logic                    err_q;
    logic                    coreStart_q;
    logic                    coreRdy_q;
    logic [WORD_BYTES*8-1:0] coreData_q;
    logic [HASH_W-1:0]       hash_q;
    logic                    coreRqPrev_q;

    logic                      coreRise;
    logic                      hostAck;
    logic [LANE_W-1:0]         laneBit;
    logic [HSEL_W-1:0]         hashBit;
    logic [7:0]                hashByte;
    logic [ADDR_W+IDX_W-1:0]   statusWord;

    assign coreRise   = bus.core_rq & ~coreRqPrev_q;
    assign hostAck    = hostRq_q & bus.host_rdy;
    assign statusWord = {bus.core_addr, idx_q};

    // Byte index to bit offset; only meaningful while idx_q is below the word/digest size.
    always_comb begin
        laneBit  = WORD_LSB_FIRST ? (LANE_W'(idx_q) << 3)
                                  : ((LANE_W'(WORD_BYTES - 1) - LANE_W'(idx_q)) << 3);
        hashBit  = HASH_LSB_FIRST ? (HSEL_W'(idx_q) << 3)
                                  : ((HSEL_W'(HASH_BYTES - 1) - HSEL_W'(idx_q)) << 3);
        hashByte = 8'(hash_q >> hashBit);
    end

    assign bus.host_out   = (state_q == S_OUT) ? hashByte : 8'(statusWord);
    assign bus.host_rq    = hostRq_q;
    assign bus.host_done  = hostDone_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
    assign bus.core_start = coreStart_q;
    assign bus.core_rdy   = coreRdy_q;
    assign bus.core_data  = coreData_q;

    // Priority: abort, then core_done (abandons any partial word), then per-state handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            hostRq_q     <= 1'b0;
            hostDone_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            coreStart_q  <= 1'b0;
            coreRdy_q    <= 1'b0;
            coreData_q   <= '0;
            hash_q       <= '0;
            coreRqPrev_q <= 1'b0;
        end else begin
            coreRqPrev_q <= bus.core_rq;
            coreStart_q  <= 1'b0;
            coreRdy_q    <= 1'b0;
            if (bus.abort) begin
                state_q    <= S_IDLE;
                busy_q     <= 1'b0;
                hostRq_q   <= 1'b0;
                hostDone_q <= 1'b0;
                idx_q      <= '0;
            end else if (bus.core_done && (state_q == S_WAIT || state_q == S_FETCH)) begin
                hash_q     <= bus.core_hash;
                hostRq_q   <= 1'b0;
                hostDone_q <= 1'b1;
                idx_q      <= '0;
                state_q    <= S_OUT;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            coreStart_q <= 1'b1;
                            err_q       <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (coreRise) begin
                            idx_q   <= '0;
                            state_q <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        // A new request before the current word is delivered is an overrun; it is dropped.
                        if (coreRise) begin
                            err_q <= 1'b1;
                        end
                        if (idx_q == IDX_W'(WORD_BYTES)) begin
                            coreRdy_q <= 1'b1;
                            idx_q     <= '0;
                            state_q   <= S_WAIT;
                        end else if (hostAck) begin
                            coreData_q[laneBit +: 8] <= bus.host_data;
                            hostRq_q                 <= 1'b0;
                            idx_q                    <= idx_q + 1'b1;
                        end else if (!hostRq_q) begin
                            hostRq_q <= 1'b1;
                        end
                    end
                    S_OUT: begin
                        if (idx_q == IDX_W'(OUT_BYTES)) begin
                            hostDone_q <= 1'b0;
                            busy_q     <= 1'b0;
                            idx_q      <= '0;
                            state_q    <= S_IDLE;
                        end else if (hostAck) begin
                            hostRq_q <= 1'b0;
                            idx_q    <= idx_q + 1'b1;
                        end else if (!hostRq_q) begin
                            hostRq_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha_host_bridge.sv
// Directed bench: default bridge (dutA) plus LSB-first word/digest, 4-byte-output variant (dutB).
// A select bit routes the shared stimulus to one instance and muxes its outputs back.
`timescale 1ns/1ps

module tb_sha_host_bridge;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sel;
    logic         start, abort, hostRdy, coreRq, coreDone;
    logic [7:0]   hostData;
    logic [4:0]   coreAddr;
    logic [255:0] coreHash;
    logic [7:0]   b;
    int           compares = 0;
    int           mismatches = 0;

    always #5 clk = ~clk;

    sha_host_bridge_if #(.WORD_BYTES(4), .HASH_BYTES(32), .ADDR_W(5)) busA ();
    sha_host_bridge_if #(.WORD_BYTES(4), .HASH_BYTES(32), .ADDR_W(5)) busB ();

    assign busA.start     = start & ~sel;
    assign busA.abort     = abort & ~sel;
    assign busA.host_rdy  = hostRdy & ~sel;
    assign busA.core_rq   = coreRq & ~sel;
    assign busA.core_done = coreDone & ~sel;
    assign busA.host_data = hostData;
    assign busA.core_addr = coreAddr;
    assign busA.core_hash = coreHash;

    assign busB.start     = start & sel;
    assign busB.abort     = abort & sel;
    assign busB.host_rdy  = hostRdy & sel;
    assign busB.core_rq   = coreRq & sel;
    assign busB.core_done = coreDone & sel;
    assign busB.host_data = hostData;
    assign busB.core_addr = coreAddr;
    assign busB.core_hash = coreHash;

    sha_host_bridge #(
        .WORD_BYTES(4), .HASH_BYTES(32), .OUT_BYTES(32), .ADDR_W(5),
        .WORD_LSB_FIRST(1'b0), .HASH_LSB_FIRST(1'b0)
    ) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));

    sha_host_bridge #(
        .WORD_BYTES(4), .HASH_BYTES(32), .OUT_BYTES(4), .ADDR_W(5),
        .WORD_LSB_FIRST(1'b1), .HASH_LSB_FIRST(1'b1)
    ) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

    logic        hostRq, hostDone, busy, err, coreStart, coreRdy;
    logic [7:0]  hostOut;
    logic [31:0] coreData;

    assign hostRq    = sel ? busB.host_rq    : busA.host_rq;
    assign hostDone  = sel ? busB.host_done  : busA.host_done;
    assign busy      = sel ? busB.busy       : busA.busy;
    assign err       = sel ? busB.err        : busA.err;
    assign coreStart = sel ? busB.core_start : busA.core_start;
    assign coreRdy   = sel ? busB.core_rdy   : busA.core_rdy;
    assign hostOut   = sel ? busB.host_out   : busA.host_out;
    assign coreData  = sel ? busB.core_data  : busA.core_data;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compares++;
        assert (observed === expected) else begin
            mismatches++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One host byte handshake: wait for host_rq, ack it a cycle later, return host_out seen during the ack.
    task automatic applyStimulus(input logic [7:0] data, output logic [7:0] seen);
        for (int i = 0; i < 40 && hostRq !== 1'b1; i++) @(negedge clk);
        checkOutput("host_rq_raised", 64'(hostRq), 64'd1);
        @(negedge clk);
        hostData = data;
        hostRdy  = 1'b1;
        seen     = hostOut;
        @(negedge clk);
        hostRdy  = 1'b0;
        checkOutput("host_rq_gap", 64'(hostRq), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] w1 [4];
        w1 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        sel = 1'b0; start = 1'b0; abort = 1'b0; hostRdy = 1'b0; coreRq = 1'b0; coreDone = 1'b0;
        hostData = 8'h00; coreAddr = 5'h03;
        for (int i = 0; i < 32; i++) coreHash[8*(31-i) +: 8] = 8'(i);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_host_rq", 64'(hostRq), 64'd0);
        checkOutput("rst_host_done", 64'(hostDone), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_core_start", 64'(coreStart), 64'd0);
        checkOutput("rst_core_rdy", 64'(coreRdy), 64'd0);
        checkOutput("rst_core_data", 64'(coreData), 64'd0);
        checkOutput("rst_host_out", 64'(hostOut), 64'hC0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] word assembly MSB first");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("core_start_pulse", 64'(coreStart), 64'd1);
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        @(negedge clk);
        checkOutput("core_start_single", 64'(coreStart), 64'd0);
        coreRq = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(w1[i], b);
        @(negedge clk);
        checkOutput("core_rdy_pulse", 64'(coreRdy), 64'd1);
        checkOutput("word_msb_first", 64'(coreData), 64'hDEADBEEF);
        @(negedge clk);
        checkOutput("core_rdy_single", 64'(coreRdy), 64'd0);
        checkOutput("status_wait", 64'(hostOut), 64'hC0);

        $display("[TB] overrun during fetch");
        coreRq = 1'b0;
        @(negedge clk);
        coreRq = 1'b1;
        applyStimulus(8'h11, b);
        coreRq = 1'b0;
        @(negedge clk);
        coreRq = 1'b1;
        @(negedge clk);
        checkOutput("err_overrun", 64'(err), 64'd1);
        applyStimulus(8'h22, b);
        applyStimulus(8'h33, b);
        applyStimulus(8'h44, b);
        @(negedge clk);
        checkOutput("word_after_overrun", 64'(coreData), 64'h11223344);
        checkOutput("core_rdy_after_overrun", 64'(coreRdy), 64'd1);

        $display("[TB] digest output");
        coreDone = 1'b1;
        @(negedge clk);
        coreDone = 1'b0;
        checkOutput("host_done_set", 64'(hostDone), 64'd1);
        checkOutput("err_sticky_out", 64'(err), 64'd1);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(8'h00, b);
            checkOutput("digest_byte", 64'(b), 64'(i));
        end
        @(negedge clk);
        checkOutput("host_done_clear", 64'(hostDone), 64'd0);
        checkOutput("busy_clear", 64'(busy), 64'd0);
        checkOutput("err_sticky_idle", 64'(err), 64'd1);
        checkOutput("status_idle", 64'(hostOut), 64'hC0);

        $display("[TB] start clears err, abort mid-word");
        start = 1'b1;
        coreRq = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("err_cleared", 64'(err), 64'd0);
        checkOutput("core_start_again", 64'(coreStart), 64'd1);
        coreRq = 1'b1;
        applyStimulus(8'hAA, b);
        applyStimulus(8'hBB, b);
        checkOutput("status_fetch_idx2", 64'(hostOut), 64'hC2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_host_rq", 64'(hostRq), 64'd0);
        checkOutput("abort_host_done", 64'(hostDone), 64'd0);
        checkOutput("abort_idx", 64'(hostOut), 64'hC0);
        checkOutput("abort_keeps_data", 64'(coreData), 64'hAABB3344);
        start = 1'b1;
        coreRq = 1'b0;
        @(negedge clk);
        start = 1'b0;
        coreRq = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(8'(i + 1), b);
        @(negedge clk);
        checkOutput("restart_core_rdy", 64'(coreRdy), 64'd1);
        checkOutput("restart_word", 64'(coreData), 64'h01020304);

        $display("[TB] core_done collides with final ack");
        coreRq = 1'b0;
        @(negedge clk);
        coreRq = 1'b1;
        applyStimulus(8'h51, b);
        applyStimulus(8'h52, b);
        applyStimulus(8'h53, b);
        for (int i = 0; i < 40 && hostRq !== 1'b1; i++) @(negedge clk);
        checkOutput("host_rq_last", 64'(hostRq), 64'd1);
        @(negedge clk);
        hostData = 8'h54;
        hostRdy  = 1'b1;
        coreDone = 1'b1;
        @(negedge clk);
        hostRdy  = 1'b0;
        coreDone = 1'b0;
        checkOutput("collide_host_done", 64'(hostDone), 64'd1);
        checkOutput("collide_host_rq", 64'(hostRq), 64'd0);
        checkOutput("collide_first_byte", 64'(hostOut), 64'h00);
        @(negedge clk);
        checkOutput("collide_no_rdy", 64'(coreRdy), 64'd0);
        checkOutput("collide_no_capture", 64'(coreData), 64'h51525304);
        checkOutput("collide_out_rq", 64'(hostRq), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_out_busy", 64'(busy), 64'd0);
        checkOutput("abort_out_done", 64'(hostDone), 64'd0);

        $display("[TB] LSB-first variant, truncated output");
        coreRq = 1'b0;
        @(negedge clk);
        sel   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b_core_start", 64'(coreStart), 64'd1);
        coreRq = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(w1[i], b);
        @(negedge clk);
        checkOutput("b_core_rdy", 64'(coreRdy), 64'd1);
        checkOutput("b_word_lsb_first", 64'(coreData), 64'hEFBEADDE);
        coreDone = 1'b1;
        @(negedge clk);
        coreDone = 1'b0;
        checkOutput("b_host_done", 64'(hostDone), 64'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h00, b);
            checkOutput("b_digest_byte", 64'(b), 64'(8'h1F - 8'(i)));
        end
        @(negedge clk);
        checkOutput("b_host_done_clear", 64'(hostDone), 64'd0);
        checkOutput("b_busy_clear", 64'(busy), 64'd0);

        $display("[TB] asynchronous reset mid-operation");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b_busy_before_rst", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", 64'(busy), 64'd0);
        checkOutput("async_rst_core_start", 64'(coreStart), 64'd0);
        checkOutput("async_rst_core_data", 64'(coreData), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule

// File: doc/sha_host_bridge.md
Name: sha_host_bridge

Overview:
- Parametrised byte-serial bridge between the 8-bit pin-level host bus and a word-request hash core (for example, the sha256d wrapper).
- Assembles WORD_BYTES host bytes into each word the core requests, then streams OUT_BYTES bytes of the finished digest back to the host.
- Generalises the fixed 4-byte / 32-byte top-level loader. Adds configurable byte order, truncated output, abort, a busy flag and overrun detection.

Parameters:
- WORD_BYTES, 4: bytes per core data word, 1..8.
- HASH_BYTES, 32: core digest width in bytes.
- OUT_BYTES, 32: digest bytes returned to the host, 1..HASH_BYTES.
- ADDR_W, 5: width of the core word address.
- WORD_LSB_FIRST, 0: 0 means the first host byte lands in the word's MSB; 1 means it lands in the LSB.
- HASH_LSB_FIRST, 0: 0 means the digest is output from the MSB byte downward; 1 means from the LSB byte upward.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: level; begins a job when sampled high in IDLE.
- abort, in, 1: synchronous; returns the block to IDLE.
- host_data, in, 8: byte from the host.
- host_rdy, in, 1: host acknowledges the current byte transfer.
- host_rq, out, 1: bridge requests a byte transfer.
- host_out, out, 8: digest byte or status.
- host_done, out, 1: high while the digest is being output.
- busy, out, 1: high whenever state is not IDLE.
- err, out, 1: sticky overrun flag.
- core_start, out, 1: one-cycle start pulse to the core.
- core_rdy, out, 1: one-cycle "word valid" pulse.
- core_data, out, WORD_BYTES*8: assembled word.
- core_rq, in, 1: core requests a word (rising edge is significant).
- core_addr, in, ADDR_W: core word index, used for status only.
- core_hash, in, HASH_BYTES*8: digest.
- core_done, in, 1: digest valid.

Behaviour:
- Reset values: all outputs 0, core_data 0, state IDLE, byte index 0.
- The clock and reset are decided: one clock, clk; reset is asynchronous and active-low, rst_n.
- States are IDLE, WAIT, FETCH and OUT. All outputs are registered except host_out.
- IDLE:
  - start=1 → pulse core_start for one cycle and clear err; go to WAIT.
  - start sampled while busy is ignored.
- WAIT:
  - A registered rising edge of core_rq (core_rq=1, previous core_rq=0) → go to FETCH with index 0.
- FETCH, host byte handshake:
  - If host_rq=0 and index<WORD_BYTES, raise host_rq.
  - On a cycle with host_rq && host_rdy:
    - Capture host_data into byte lane index of core_data.
    - Lane numbering: lane 0 is the MSB when WORD_LSB_FIRST=0, the LSB otherwise.
    - Drop host_rq and increment index.
  - host_rq is therefore low for at least one cycle between bytes.
  - host_rdy while host_rq=0 is ignored.
- FETCH, word completion:
  - When index==WORD_BYTES, pulse core_rdy for one cycle, reset index to 0 and return to WAIT.
  - core_data holds its value until the next capture.
- Overrun: a core_rq rising edge seen while in FETCH sets err. The current word continues; the extra request is dropped.
- core_done in WAIT or FETCH:
  - Latch core_hash into an internal register.
  - Abandon any partial word, clear host_rq, set index 0, set host_done=1 and go to OUT.
  - core_done has priority over a simultaneous byte capture or word completion.
- OUT:
  - Same rq/rdy handshake as FETCH; each acknowledged transfer increments the index.
  - host_out is latched digest byte index: byte 0 is the MSB when HASH_LSB_FIRST=0, the LSB otherwise.
  - When index==OUT_BYTES, host_done returns to 0 and state returns to IDLE with index 0.
- host_out outside OUT: low 8 bits of {core_addr, index}. Index width is clog2(max(WORD_BYTES,OUT_BYTES)+1).
- abort=1 in any state:
  - Next cycle, state is IDLE and host_rq, host_done, core_rdy and core_start are 0; index is 0.
  - err and core_data are retained.
  - abort has priority over every other event, including start.
- Reset mid-operation forces reset values immediately and asynchronously.
- Elaboration errors: OUT_BYTES>HASH_BYTES, or WORD_BYTES outside 1..8.

Test Plan:
- Defaults; start=1; core_rq rises; host supplies 0xDE,0xAD,0xBE,0xEF, each acked one cycle after host_rq → core_rdy pulses once with core_data=0xDEADBEEF; host_rq is low ≥1 cycle between bytes.
- Same bytes with WORD_LSB_FIRST=1 → core_data=0xEFBEADDE.
- core_done with core_hash=0x00 01 02 … 1F (MSB first); host acks 32 bytes → host_out sequence 0x00..0x1F, then host_done=0 and busy=0. With OUT_BYTES=4 and HASH_LSB_FIRST=1 → sequence 0x1F,0x1E,0x1D,0x1C.
- Second core_rq rising edge during FETCH → err=1 and stays 1 through OUT; next start clears it.
- abort during FETCH after 2 bytes → next cycle IDLE, host_rq=0, busy=0; a new start works normally from index 0.
- core_done asserted in the same cycle as the final host byte ack → no core_rdy pulse; OUT entered with index 0.
